imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader on the write side of the instruction memory: fills memory that the fetch stage later reads by word index.
- Receives a byte stream over a valid/ready handshake: a 16-bit little-endian word count N, then 4*N instruction bytes.
- Assembles the bytes into little-endian 32-bit words, writes them to consecutive word addresses from 0, and holds the CPU while loading.
- Sits between the host/debug byte link and the instruction memory write port.

Parameters:
PC_SIZE, 32, width of mem_addr; matches the instruction memory address width
MEM_SIZE, 1024, number of 32-bit words in instruction memory; maximum legal N
LEN_WIDTH, 16, width of the word-count header; fixed at two bytes

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising clk edge
start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  one-cycle write strobe to instruction memory
mem_addr  output  PC_SIZE  word index being written
mem_wdata  output  32  assembled instruction word
cpu_hold  output  1  holds the CPU/PC while a load is in progress
done  output  1  load completed successfully (level)
error  output  1  header rejected (level)

Behaviour:
- Reset values: state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0; byte counter, word counter and N register all 0.
- Handshake: a byte transfers when in_valid && in_ready on a rising edge. in_data is sampled only on a transfer. in_ready is a registered function of state: 1 in LEN_LO, LEN_HI and DATA; 0 otherwise.
- States:
  - IDLE: on start -> LEN_LO; cpu_hold<=1, done<=0, error<=0, mem_addr<=0.
  - LEN_LO: on transfer, N[7:0]<=in_data -> LEN_HI.
  - LEN_HI: on transfer, N[15:8]<=in_data. Next state is decided on the full 16-bit N:
    - N==0 -> DONE.
    - N>MEM_SIZE -> ERROR.
    - otherwise -> DATA.
  - DATA: byte k of a word (k=0..3) goes to bits [8k+7:8k] of the word shift register.
    - On the 4th transfer, the next cycle drives mem_we=1, mem_wdata=assembled word, mem_addr=current word index. Latency is exactly 1 cycle after the 4th handshake.
    - mem_addr increments by 1 in the cycle after the strobe.
    - After the N-th word's strobe -> DONE.
    - in_ready stays 1 during the strobe cycle, so a zero-bubble stream of 4 bytes per 4 cycles is sustained.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> LEN_LO (clears done).
  - ERROR: error=1, cpu_hold stays 1, in_ready=0, no writes. start -> LEN_LO (clears error).
- mem_addr after a load equals the last written index. Writes never exceed MEM_SIZE-1, because N>MEM_SIZE is rejected and N==MEM_SIZE is legal.
- in_valid gaps stall progress indefinitely with no timeout; the partially assembled word is retained.
- start while in LEN_LO, LEN_HI or DATA is ignored.
- Bytes offered in IDLE, DONE or ERROR are not accepted (in_ready=0) and are not consumed.
- Reset mid-load: returns to IDLE on the next edge, cpu_hold drops to 0, and a pending strobe is cancelled. Memory contents already written are not cleared by this block.
- mem_we is never high in two consecutive cycles.

Test Plan:
- Basic load: start; bytes 02 00, then 13 00 00 00, then 93 00 10 00 -> mem_we pulses twice, 1 cycle after the 4th and 8th data handshakes. First pulse writes addr 0, data 0x00000013; second writes addr 1, data 0x00100093. Then done=1, cpu_hold=0.
- Empty program: start; bytes 00 00 -> DONE the cycle after the 2nd byte, no mem_we, done=1.
- Oversize header (MEM_SIZE=1024): bytes 01 04 (N=1025) -> error=1, cpu_hold=1, in_ready=0, no writes. A following start re-enters LEN_LO with error=0.
- Boundary and back-pressure: N=1024 with in_valid toggled on a random pattern -> 1024 strobes at addresses 0..1023 in order, the last at addr 1023, data matching the stream, no strobe beyond 1023.
- Reset mid-load: assert reset after the 2nd byte of word 1 -> all outputs reach reset values next edge. A new start with N=1, bytes AA BB CC DD -> writes addr 0, data 0xDDCCBBAA.
- Back-to-back: stream all bytes with in_valid held high -> one strobe every 4 cycles. A start pulse during DATA is ignored and the word count is unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the program loader.
interface imem_loader_if #(
    parameter int PC_SIZE = 32
) ();
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               mem_we;
    logic [PC_SIZE-1:0] mem_addr;
    logic [31:0]        mem_wdata;

    // Host/memory side: supplies bytes, observes the write port.
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes bytes, drives the write port.
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: takes a 16-bit little-endian word count
// followed by the program bytes, packs them into 32-bit little-endian words
// and writes them to consecutive word addresses from 0 while holding the CPU.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_LO | waiting for word-count low byte
// LEN_HI | waiting for word-count high byte, header checked here
// DATA   | assembling and writing instruction words
// DONE   | load finished, CPU released
// ERROR  | header rejected (count too large), CPU still held
module imem_loader #(
    parameter int PC_SIZE   = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int LEN_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           error
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR
    } state_t;

    localparam logic [LEN_WIDTH:0] MAX_N = (LEN_WIDTH + 1)'(MEM_SIZE);

    state_t                 state, state_nx;
    logic [LEN_WIDTH-1:0]   n_len, n_nx;
    logic [LEN_WIDTH-1:0]   word_cnt, word_nx, word_inc;
    logic [1:0]             byte_cnt, byte_nx;
    logic [31:0]            shift, shift_nx;
    logic                   we_r, we_nx;
    logic [PC_SIZE-1:0]     addr_r, addr_nx;
    logic [31:0]            wdata_r, wdata_nx;
    logic                   rdy_r, rdy_nx;
    logic                   hold_r, hold_nx;
    logic                   done_r, done_nx;
    logic                   err_r, err_nx;
    logic                   xfer;
    logic [LEN_WIDTH-1:0]   hdr_len;

    assign xfer     = bus.in_valid && rdy_r;
    assign hdr_len  = {bus.in_data, n_len[7:0]};
    assign word_inc = word_cnt + LEN_WIDTH'(1);

    assign bus.in_ready  = rdy_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign cpu_hold      = hold_r;
    assign done          = done_r;
    assign error         = err_r;

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n_len    <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdy_r    <= 1'b0;
            hold_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_nx;
            n_len    <= n_nx;
            word_cnt <= word_nx;
            byte_cnt <= byte_nx;
            shift    <= shift_nx;
            we_r     <= we_nx;
            addr_r   <= addr_nx;
            wdata_r  <= wdata_nx;
            rdy_r    <= rdy_nx;
            hold_r   <= hold_nx;
            done_r   <= done_nx;
            err_r    <= err_nx;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nx = state;
        n_nx     = n_len;
        word_nx  = word_cnt;
        byte_nx  = byte_cnt;
        shift_nx = shift;
        we_nx    = 1'b0;
        addr_nx  = addr_r;
        wdata_nx = wdata_r;
        rdy_nx   = rdy_r;
        hold_nx  = hold_r;
        done_nx  = done_r;
        err_nx   = err_r;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nx = LEN_LO;
                    hold_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                    addr_nx  = '0;
                    n_nx     = '0;
                    word_nx  = '0;
                    byte_nx  = '0;
                    rdy_nx   = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    n_nx[7:0] = bus.in_data;
                    state_nx  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    n_nx = hdr_len;
                    if (hdr_len == '0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        hold_nx  = 1'b0;
                        rdy_nx   = 1'b0;
                    end else if ({1'b0, hdr_len} > MAX_N) begin
                        state_nx = ERROR;
                        err_nx   = 1'b1;
                        rdy_nx   = 1'b0;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                // Strobe cycle: either finish or advance to the next word index.
                if (we_r) begin
                    if (word_cnt == n_len) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        hold_nx  = 1'b0;
                        rdy_nx   = 1'b0;
                    end else begin
                        addr_nx = addr_r + PC_SIZE'(1);
                    end
                end
                if (xfer) begin
                    shift_nx[{byte_cnt, 3'b000} +: 8] = bus.in_data;
                    byte_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        we_nx    = 1'b1;
                        wdata_nx = {bus.in_data, shift[23:0]};
                        word_nx  = word_inc;
                        // No byte may be taken during the final strobe.
                        if (word_inc == n_len) begin
                            rdy_nx = 1'b0;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads with random data and
// back-pressure checked against a byte-stream model, plus hand-written
// sequences for reset, error recovery and idle-state behaviour.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    imem_loader_if #(.PC_SIZE(32)) bus ();

    imem_loader #(.PC_SIZE(32), .MEM_SIZE(1024), .LEN_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observation of handshakes and memory writes, sampled mid-cycle.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int   cyc = 0;
    int   hsq[$];
    wr_t  wrq[$];
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) hsq.push_back(cyc);
        if (bus.mem_we) begin
            wrq.push_back('{bus.mem_addr, bus.mem_wdata, cyc});
            check("we_not_consecutive", 64'(prev_we), 64'(0));
        end
        prev_we = bus.mem_we;
    end

    logic [7:0] stream[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int w;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            step();
            w++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
        end else begin
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // One full load: header n, then the bytes in `stream` unless rejected.
    task automatic run_load(input logic [15:0] n, input int gap, input bit mid_start,
                            input bit exp_err, input int exp_wr);
        int w;
        int bad;
        logic [31:0] exp_word;
        do_start();
        wrq.delete();
        hsq.delete();
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        if (!exp_err) begin
            for (int i = 0; i < stream.size(); i++) begin
                if (mid_start && i == 5) start = 1'b1;
                send_byte(stream[i], gap);
                start = 1'b0;
            end
        end
        w = 0;
        while (!(done || error) && w < 20) begin
            step();
            w++;
        end
        check("finish_latency", 64'(w), 64'((exp_err || n == 0) ? 0 : 1));
        check("done", 64'(done), 64'(!exp_err));
        check("error", 64'(error), 64'(exp_err));
        check("cpu_hold", 64'(cpu_hold), 64'(exp_err));
        check("in_ready_after", 64'(bus.in_ready), 64'(0));
        check("write_count", 64'(wrq.size()), 64'(exp_wr));
        bad = -1;
        for (int k = 0; k < wrq.size() && k < exp_wr; k++) begin
            exp_word = {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]};
            if (bad < 0 && (wrq[k].addr !== 32'(k) || wrq[k].data !== exp_word ||
                            (4*k + 5 >= hsq.size()) || wrq[k].cyc != hsq[4*k+5] + 1))
                bad = k;
        end
        check("write_stream_bad_index", 64'(bad), 64'(-1));
        if (!exp_err && n != 0)
            check("final_mem_addr", 64'(bus.mem_addr), 64'(n - 1));
        if (gap == 0 && hsq.size() > 1)
            check("zero_bubble", 64'(hsq[hsq.size()-1] - hsq[0]), 64'(hsq.size() - 1));
    endtask

    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          mid_start;
        bit          exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vecs[7];
    int   n0;

    initial begin
        vecs[0] = '{16'd1,     0,  1'b0, 1'b0, 1};
        vecs[1] = '{16'd3,     30, 1'b0, 1'b0, 3};
        vecs[2] = '{16'd0,     0,  1'b0, 1'b0, 0};
        vecs[3] = '{16'd1025,  0,  1'b0, 1'b1, 0};
        vecs[4] = '{16'd65535, 20, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd1024,  40, 1'b0, 1'b0, 1024};
        vecs[6] = '{16'd8,     0,  1'b1, 1'b0, 8};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_mem_we", 64'(bus.mem_we), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(0));
        check("rst_done_error", 64'({done, error}), 64'(0));

        // Bytes offered while idle are not accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        hsq.delete();
        repeat (3) step();
        bus.in_valid = 1'b0;
        check("idle_no_consume", 64'(hsq.size()), 64'(0));

        // Basic load with fixed instructions.
        stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(16'd2, 0, 1'b0, 1'b0, 2);
        if (wrq.size() == 2) begin
            check("basic_w0", 64'({wrq[0].addr, wrq[0].data}), {32'd0, 32'h0000_0013});
            check("basic_w1", 64'({wrq[1].addr, wrq[1].data}), {32'd1, 32'h0010_0093});
        end else begin
            check("basic_write_count", 64'(wrq.size()), 64'(2));
        end

        // Bytes offered in DONE are not consumed.
        n0 = hsq.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (3) step();
        bus.in_valid = 1'b0;
        check("done_no_consume", 64'(hsq.size()), 64'(n0));
        check("done_holds", 64'(done), 64'(1));

        // Table of loads with random data.
        foreach (vecs[v]) begin
            stream.delete();
            if (!vecs[v].exp_err)
                for (int i = 0; i < 4 * int'(vecs[v].n); i++)
                    stream.push_back(8'($urandom_range(255)));
            run_load(vecs[v].n, vecs[v].gap, vecs[v].mid_start, vecs[v].exp_err, vecs[v].exp_wr);
        end

        // Recovery from ERROR (table left the loader rejected by the last error vector? re-create it).
        stream.delete();
        run_load(16'd1025, 0, 1'b0, 1'b1, 0);
        do_start();
        check("err_restart_error", 64'(error), 64'(0));
        check("err_restart_ready", 64'(bus.in_ready), 64'(1));
        check("err_restart_hold", 64'(cpu_hold), 64'(1));
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("err_then_empty_done", 64'(done), 64'(1));

        // Reset mid-load, after two bytes of the first word.
        do_start();
        wrq.delete();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        step();
        check("midrst_outputs",
              64'({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, error}),
              64'(0));
        reset = 1'b0;

        // Reset coinciding with the 4th byte cancels the strobe.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0a, 0);
        send_byte(8'h0b, 0);
        send_byte(8'h0c, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0d;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) step();
        check("strobe_cancelled", 64'(wrq.size()), 64'(0));
        check("rst_hold_dropped", 64'(cpu_hold), 64'(0));

        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(16'd1, 0, 1'b0, 1'b0, 1);
        if (wrq.size() == 1)
            check("after_rst_word", 64'({wrq[0].addr, wrq[0].data}), {32'd0, 32'hDDCC_BBAA});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
